video_palette_port: RTL and testbench

VIDEO_PALETTE_PORT -- requirements
Module: video_palette_port

---
 rtl/video_palette_port_if.sv | 32 +++
 rtl/video_palette_port.sv | 129 ++++++++++++
 tb/tb_video_palette_port.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/video_palette_port_if.sv
// CPU register, palette RAM and VRAM signals of the video palette port.
// The slave modport is the port logic; the master modport is whoever drives it.
interface video_palette_port_if;
  logic [2:0]  I_reg_sel;
  logic        I_reg_wr;
  logic        I_reg_rd;
  logic [7:0]  I_reg_data;
  logic [7:0]  O_reg_data;
  logic        O_reg_valid;
  logic        O_busy;
  logic [4:0]  O_pal_addr;
  logic        O_pal_wren;
  logic [5:0]  O_pal_data;
  logic [5:0]  I_pal_data;
  logic [13:0] O_vram_addr;
  logic        O_vram_wr;
  logic        O_vram_rd;
  logic [7:0]  O_vram_wdata;
  logic [7:0]  I_vram_rdata;

  modport slave (
    input  I_reg_sel, I_reg_wr, I_reg_rd, I_reg_data, I_pal_data, I_vram_rdata,
    output O_reg_data, O_reg_valid, O_busy, O_pal_addr, O_pal_wren, O_pal_data,
           O_vram_addr, O_vram_wr, O_vram_rd, O_vram_wdata
  );

  modport master (
    output I_reg_sel, I_reg_wr, I_reg_rd, I_reg_data, I_pal_data, I_vram_rdata,
    input  O_reg_data, O_reg_valid, O_busy, O_pal_addr, O_pal_wren, O_pal_data,
           O_vram_addr, O_vram_wr, O_vram_rd, O_vram_wdata
  );
endinterface

// File: rtl/video_palette_port.sv
// CPU-facing data port for palette RAM and VRAM: two-write address latch,
// auto-increment, and a buffered read sequence (palette reads bypass the buffer).
//
// state   | meaning
// IDLE    | accepting register accesses
// RD_ADDR | read address and O_vram_rd presented
// RD_DATA | waiting for palette / VRAM read data
// RD_DONE | O_reg_data valid for one clock
module video_palette_port (
  input logic I_clock,
  input logic I_reset,
  video_palette_port_if.slave bus
);

  localparam logic [2:0] SEL_CTRL   = 3'd0;
  localparam logic [2:0] SEL_STATUS = 3'd2;
  localparam logic [2:0] SEL_ADDR   = 3'd6;
  localparam logic [2:0] SEL_DATA   = 3'd7;

  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA, RD_DONE} state_t;

  state_t      state;
  logic        inc32;
  logic        w_toggle;
  logic [13:0] t_addr;
  logic [13:0] v_addr;
  logic [7:0]  rd_buf;
  logic        rd_pal;

  logic [13:0] v_next;
  logic        in_pal;
  logic [4:0]  pal_idx;
  logic        wr_acc;
  logic        rd_acc;

  assign v_next  = v_addr + (inc32 ? 14'd32 : 14'd1);
  assign in_pal  = (v_addr[13:8] == 6'h3F);
  // Entries 0x10/0x14/0x18/0x1C alias the backdrop entries below them
  assign pal_idx = {v_addr[4] & (v_addr[1:0] != 2'b00), v_addr[3:0]};
  assign wr_acc  = bus.I_reg_wr & (state == IDLE);
  assign rd_acc  = bus.I_reg_rd & ~bus.I_reg_wr & (state == IDLE);

  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      state            <= IDLE;
      inc32            <= 1'b0;
      w_toggle         <= 1'b0;
      t_addr           <= '0;
      v_addr           <= '0;
      rd_buf           <= '0;
      rd_pal           <= 1'b0;
      bus.O_reg_data   <= '0;
      bus.O_reg_valid  <= 1'b0;
      bus.O_busy       <= 1'b0;
      bus.O_pal_addr   <= '0;
      bus.O_pal_wren   <= 1'b0;
      bus.O_pal_data   <= '0;
      bus.O_vram_addr  <= '0;
      bus.O_vram_wr    <= 1'b0;
      bus.O_vram_rd    <= 1'b0;
      bus.O_vram_wdata <= '0;
    end else begin
      bus.O_pal_wren  <= 1'b0;
      bus.O_vram_wr   <= 1'b0;
      bus.O_vram_rd   <= 1'b0;
      bus.O_reg_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_acc) begin
            case (bus.I_reg_sel)
              SEL_CTRL: inc32 <= bus.I_reg_data[2];
              SEL_ADDR: begin
                if (!w_toggle) begin
                  t_addr   <= {bus.I_reg_data[5:0], t_addr[7:0]};
                  w_toggle <= 1'b1;
                end else begin
                  t_addr   <= {t_addr[13:8], bus.I_reg_data};
                  v_addr   <= {t_addr[13:8], bus.I_reg_data};
                  w_toggle <= 1'b0;
                end
              end
              SEL_DATA: begin
                v_addr <= v_next;
                if (in_pal) begin
                  bus.O_pal_wren <= 1'b1;
                  bus.O_pal_addr <= pal_idx;
                  bus.O_pal_data <= bus.I_reg_data[5:0];
                end else begin
                  bus.O_vram_wr    <= 1'b1;
                  bus.O_vram_addr  <= v_addr;
                  bus.O_vram_wdata <= bus.I_reg_data;
                end
              end
              default: ;
            endcase
          end else if (rd_acc) begin
            case (bus.I_reg_sel)
              SEL_STATUS: w_toggle <= 1'b0;
              SEL_DATA: begin
                state           <= RD_ADDR;
                bus.O_busy      <= 1'b1;
                bus.O_vram_rd   <= 1'b1;
                // Palette reads still refill the buffer from the nametable underneath
                bus.O_vram_addr <= in_pal ? (v_addr & 14'h2FFF) : v_addr;
                bus.O_pal_addr  <= pal_idx;
                rd_pal          <= in_pal;
                v_addr          <= v_next;
              end
              default: ;
            endcase
          end
        end
        RD_ADDR: state <= RD_DATA;
        RD_DATA: begin
          state           <= RD_DONE;
          bus.O_reg_valid <= 1'b1;
          bus.O_reg_data  <= rd_pal ? {2'b00, bus.I_pal_data} : rd_buf;
          rd_buf          <= bus.I_vram_rdata;
        end
        RD_DONE: begin
          state      <= IDLE;
          bus.O_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_palette_port.sv
// Directed bench for video_palette_port: a per-clock vector table for the main
// register flows, plus hand-written busy-lockout and reset-abort sequences.
module tb_video_palette_port;

  localparam logic [2:0] S_C = 3'd0;
  localparam logic [2:0] S_S = 3'd2;
  localparam logic [2:0] S_A = 3'd6;
  localparam logic [2:0] S_D = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done = 1'b0;

  video_palette_port_if bus ();
  video_palette_port dut (.I_clock(clk), .I_reset(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic        wr;
    logic        rd;
    logic [7:0]  wd;
    logic [5:0]  pd;
    logic [7:0]  vd;
    logic [2:0]  strb;   // {pal_wren, vram_wr, vram_rd}
    logic        busy;
    logic        valid;
    logic [7:0]  rdata;
    logic [4:0]  paddr;
    logic [13:0] vaddr;
    logic [5:0]  pdata;
    logic [7:0]  vwdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [2:0] sel, input logic wr, input logic rd,
                     input logic [7:0] wd, input logic [5:0] pd, input logic [7:0] vd,
                     input logic [2:0] strb, input logic busy, input logic valid,
                     input logic [7:0] rdata, input logic [4:0] paddr,
                     input logic [13:0] vaddr, input logic [5:0] pdata,
                     input logic [7:0] vwdata);
    vec_t v;
    v.sel = sel; v.wr = wr; v.rd = rd; v.wd = wd; v.pd = pd; v.vd = vd;
    v.strb = strb; v.busy = busy; v.valid = valid; v.rdata = rdata;
    v.paddr = paddr; v.vaddr = vaddr; v.pdata = pdata; v.vwdata = vwdata;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] sel, input logic wr, input logic rd,
                       input logic [7:0] wd);
    bus.I_reg_sel  = sel;
    bus.I_reg_wr   = wr;
    bus.I_reg_rd   = rd;
    bus.I_reg_data = wd;
    @(posedge clk);
    #1;
    bus.I_reg_wr = 1'b0;
    bus.I_reg_rd = 1'b0;
  endtask

  task automatic check_all_zero(input int idx);
    cmp("rst_reg_data", idx, 32'(bus.O_reg_data), 32'h0);
    cmp("rst_reg_valid", idx, 32'(bus.O_reg_valid), 32'h0);
    cmp("rst_busy", idx, 32'(bus.O_busy), 32'h0);
    cmp("rst_pal_addr", idx, 32'(bus.O_pal_addr), 32'h0);
    cmp("rst_pal_wren", idx, 32'(bus.O_pal_wren), 32'h0);
    cmp("rst_pal_data", idx, 32'(bus.O_pal_data), 32'h0);
    cmp("rst_vram_addr", idx, 32'(bus.O_vram_addr), 32'h0);
    cmp("rst_vram_wr", idx, 32'(bus.O_vram_wr), 32'h0);
    cmp("rst_vram_rd", idx, 32'(bus.O_vram_rd), 32'h0);
    cmp("rst_vram_wdata", idx, 32'(bus.O_vram_wdata), 32'h0);
  endtask

  // Strobes must be mutually exclusive on every clock
  always @(negedge clk) begin
    if (!done) begin
      cmp("strobe_onehot", 0,
          32'($countones({bus.O_pal_wren, bus.O_vram_wr, bus.O_vram_rd}) > 1), 32'h0);
    end
  end

  initial begin
    bus.I_reg_sel = 3'd0; bus.I_reg_wr = 1'b0; bus.I_reg_rd = 1'b0;
    bus.I_reg_data = 8'h00; bus.I_pal_data = 6'h00; bus.I_vram_rdata = 8'h00;

    // palette write with mirror, v -> 3F11 (observed through the next read address)
    add(S_A,1,0,8'h3F, 0,0,    3'b000,0,0,8'h00, 5'h00,14'h0000,6'h00,8'h00);
    add(S_A,1,0,8'h10, 0,0,    3'b000,0,0,8'h00, 5'h00,14'h0000,6'h00,8'h00);
    add(S_D,1,0,8'h2A, 0,0,    3'b100,0,0,8'h00, 5'h00,14'h0000,6'h2A,8'h00);
    add(S_D,0,0,8'h00, 0,0,    3'b000,0,0,8'h00, 5'h00,14'h0000,6'h2A,8'h00);
    add(S_D,0,1,8'h00, 0,0,    3'b001,1,0,8'h00, 5'h11,14'h2F11,6'h2A,8'h00);
    add(S_D,0,0,8'h00, 6'h0C,8'h99, 3'b000,1,0,8'h00, 5'h11,14'h2F11,6'h2A,8'h00);
    add(S_D,0,0,8'h00, 6'h0C,8'h99, 3'b000,1,1,8'h0C, 5'h11,14'h2F11,6'h2A,8'h00);
    add(S_D,0,0,8'h00, 0,0,    3'b000,0,0,8'h0C, 5'h11,14'h2F11,6'h2A,8'h00);
    // palette read of entry 5
    add(S_A,1,0,8'h3F, 0,0,    3'b000,0,0,8'h0C, 5'h11,14'h2F11,6'h2A,8'h00);
    add(S_A,1,0,8'h05, 0,0,    3'b000,0,0,8'h0C, 5'h11,14'h2F11,6'h2A,8'h00);
    add(S_D,0,1,8'h00, 0,0,    3'b001,1,0,8'h0C, 5'h05,14'h2F05,6'h2A,8'h00);
    add(S_D,0,0,8'h00, 6'h16,8'h77, 3'b000,1,0,8'h0C, 5'h05,14'h2F05,6'h2A,8'h00);
    add(S_D,0,0,8'h00, 6'h16,8'h77, 3'b000,1,1,8'h16, 5'h05,14'h2F05,6'h2A,8'h00);
    add(S_D,0,0,8'h00, 0,0,    3'b000,0,0,8'h16, 5'h05,14'h2F05,6'h2A,8'h00);
    add(S_D,0,1,8'h00, 0,0,    3'b001,1,0,8'h16, 5'h06,14'h2F06,6'h2A,8'h00);
    add(S_D,0,0,8'h00, 6'h01,8'h00, 3'b000,1,0,8'h16, 5'h06,14'h2F06,6'h2A,8'h00);
    add(S_D,0,0,8'h00, 6'h01,8'h00, 3'b000,1,1,8'h01, 5'h06,14'h2F06,6'h2A,8'h00);
    add(S_D,0,0,8'h00, 0,0,    3'b000,0,0,8'h01, 5'h06,14'h2F06,6'h2A,8'h00);
    // buffered VRAM reads with inc32
    add(S_C,1,0,8'h04, 0,0,    3'b000,0,0,8'h01, 5'h06,14'h2F06,6'h2A,8'h00);
    add(S_A,1,0,8'h20, 0,0,    3'b000,0,0,8'h01, 5'h06,14'h2F06,6'h2A,8'h00);
    add(S_A,1,0,8'h00, 0,0,    3'b000,0,0,8'h01, 5'h06,14'h2F06,6'h2A,8'h00);
    add(S_D,0,1,8'h00, 0,0,    3'b001,1,0,8'h01, 5'h00,14'h2000,6'h2A,8'h00);
    add(S_D,0,0,8'h00, 6'h3F,8'h55, 3'b000,1,0,8'h01, 5'h00,14'h2000,6'h2A,8'h00);
    add(S_D,0,0,8'h00, 6'h3F,8'h55, 3'b000,1,1,8'h00, 5'h00,14'h2000,6'h2A,8'h00);
    add(S_D,0,0,8'h00, 0,0,    3'b000,0,0,8'h00, 5'h00,14'h2000,6'h2A,8'h00);
    add(S_D,0,1,8'h00, 0,0,    3'b001,1,0,8'h00, 5'h00,14'h2020,6'h2A,8'h00);
    add(S_D,0,0,8'h00, 0,8'hAA, 3'b000,1,0,8'h00, 5'h00,14'h2020,6'h2A,8'h00);
    add(S_D,0,0,8'h00, 0,8'hAA, 3'b000,1,1,8'h55, 5'h00,14'h2020,6'h2A,8'h00);
    add(S_D,0,0,8'h00, 0,0,    3'b000,0,0,8'h55, 5'h00,14'h2020,6'h2A,8'h00);
    add(S_C,1,0,8'h00, 0,0,    3'b000,0,0,8'h55, 5'h00,14'h2020,6'h2A,8'h00);
    add(S_D,1,0,8'hC3, 0,0,    3'b010,0,0,8'h55, 5'h00,14'h2040,6'h2A,8'hC3);
    add(S_D,0,0,8'h00, 0,0,    3'b000,0,0,8'h55, 5'h00,14'h2040,6'h2A,8'hC3);
    // STATUS clears the toggle, then 3FFF wraps to 0000
    add(S_A,1,0,8'h3F, 0,0,    3'b000,0,0,8'h55, 5'h00,14'h2040,6'h2A,8'hC3);
    add(S_S,0,1,8'h00, 0,0,    3'b000,0,0,8'h55, 5'h00,14'h2040,6'h2A,8'hC3);
    add(S_A,1,0,8'h3F, 0,0,    3'b000,0,0,8'h55, 5'h00,14'h2040,6'h2A,8'hC3);
    add(S_A,1,0,8'hFF, 0,0,    3'b000,0,0,8'h55, 5'h00,14'h2040,6'h2A,8'hC3);
    add(S_D,1,0,8'h15, 0,0,    3'b100,0,0,8'h55, 5'h1F,14'h2040,6'h15,8'hC3);
    add(S_D,0,0,8'h00, 0,0,    3'b000,0,0,8'h55, 5'h1F,14'h2040,6'h15,8'hC3);
    add(S_D,1,0,8'h81, 0,0,    3'b010,0,0,8'h55, 5'h1F,14'h0000,6'h15,8'h81);
    add(S_D,0,0,8'h00, 0,0,    3'b000,0,0,8'h55, 5'h1F,14'h0000,6'h15,8'h81);
    // write+read together is a write; reads of non-readable registers do nothing
    add(S_D,1,1,8'h42, 0,0,    3'b010,0,0,8'h55, 5'h1F,14'h0001,6'h15,8'h42);
    add(S_D,0,0,8'h00, 0,0,    3'b000,0,0,8'h55, 5'h1F,14'h0001,6'h15,8'h42);
    add(3'd5,0,1,8'h00, 0,0,   3'b000,0,0,8'h55, 5'h1F,14'h0001,6'h15,8'h42);
    add(S_C,0,1,8'h00, 0,0,    3'b000,0,0,8'h55, 5'h1F,14'h0001,6'h15,8'h42);

    repeat (2) @(posedge clk);
    #1;
    check_all_zero(0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.I_reg_sel    = vecs[i].sel;
      bus.I_reg_wr     = vecs[i].wr;
      bus.I_reg_rd     = vecs[i].rd;
      bus.I_reg_data   = vecs[i].wd;
      bus.I_pal_data   = vecs[i].pd;
      bus.I_vram_rdata = vecs[i].vd;
      @(posedge clk);
      #1;
      cmp("strobes", i, 32'({bus.O_pal_wren, bus.O_vram_wr, bus.O_vram_rd}), 32'(vecs[i].strb));
      cmp("busy", i, 32'(bus.O_busy), 32'(vecs[i].busy));
      cmp("valid", i, 32'(bus.O_reg_valid), 32'(vecs[i].valid));
      cmp("reg_data", i, 32'(bus.O_reg_data), 32'(vecs[i].rdata));
      cmp("pal_addr", i, 32'(bus.O_pal_addr), 32'(vecs[i].paddr));
      cmp("vram_addr", i, 32'(bus.O_vram_addr), 32'(vecs[i].vaddr));
      cmp("pal_data", i, 32'(bus.O_pal_data), 32'(vecs[i].pdata));
      cmp("vram_wdata", i, 32'(bus.O_vram_wdata), 32'(vecs[i].vwdata));
    end
    bus.I_reg_wr = 1'b0;
    bus.I_reg_rd = 1'b0;

    // Busy lockout: a write one clock after a read start is dropped, v=0002
    drive(S_D, 0, 1, 8'h00);
    cmp("busy_rd_addr", 1, 32'(bus.O_vram_addr), 32'h0002);
    drive(S_D, 1, 0, 8'h99);
    cmp("busy_no_pwr", 1, 32'(bus.O_pal_wren), 32'h0);
    cmp("busy_no_vwr", 1, 32'(bus.O_vram_wr), 32'h0);
    cmp("busy_held", 1, 32'(bus.O_busy), 32'h1);
    drive(S_D, 0, 0, 8'h00);
    cmp("busy_done_valid", 1, 32'(bus.O_reg_valid), 32'h1);
    cmp("busy_done_vwr", 1, 32'(bus.O_vram_wr), 32'h0);
    drive(S_D, 0, 0, 8'h00);
    drive(S_D, 1, 0, 8'h5A);
    cmp("busy_next_vwr", 2, 32'(bus.O_vram_wr), 32'h1);
    cmp("busy_next_addr", 2, 32'(bus.O_vram_addr), 32'h0003);
    cmp("busy_next_wdata", 2, 32'(bus.O_vram_wdata), 32'h5A);

    // Reset in RD_DATA aborts the read and clears inc32 and the toggle
    drive(S_C, 1, 0, 8'h04);
    drive(S_A, 1, 0, 8'h12);
    drive(S_D, 0, 1, 8'h00);
    drive(S_D, 0, 0, 8'h00);
    cmp("abort_busy", 3, 32'(bus.O_busy), 32'h1);
    #1 rst = 1'b1;
    #1;
    check_all_zero(3);
    repeat (2) begin
      @(posedge clk);
      #1;
      cmp("abort_valid_rst", 3, 32'(bus.O_reg_valid), 32'h0);
    end
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      cmp("abort_valid_post", 4, 32'(bus.O_reg_valid), 32'h0);
      cmp("abort_busy_post", 4, 32'(bus.O_busy), 32'h0);
    end
    drive(S_A, 1, 0, 8'h01);
    drive(S_A, 1, 0, 8'h23);
    drive(S_D, 1, 0, 8'h11);
    cmp("post_vwr", 5, 32'(bus.O_vram_wr), 32'h1);
    cmp("post_addr", 5, 32'(bus.O_vram_addr), 32'h0123);
    cmp("post_wdata", 5, 32'(bus.O_vram_wdata), 32'h11);
    drive(S_D, 0, 0, 8'h00);
    drive(S_D, 1, 0, 8'h22);
    cmp("post_inc1_addr", 6, 32'(bus.O_vram_addr), 32'h0124);

    drive(S_D, 0, 0, 8'h00);
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
